// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES-128 encryption sequencer.
//   - aes_state_e : sequencer FSM states
//   - RCON        : round constants indexed by round number 1..10
//   - NR_MAX      : largest supported round count
//   - byte_idx / byte_msb : column-major byte addressing (bit 127 = byte 0)
//   - round datapath stages: sbox, sub_bytes, shift_rows, mix_columns, add_round_key
package aes_pkg;

    localparam int unsigned NR_MAX = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal,
        StDone
    } aes_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Column-major: byte (row r, column c) is byte number 4*c + r.
    function automatic logic [3:0] byte_idx(input logic [1:0] r, input logic [1:0] c);
        return {c, r};
    endfunction

    // MSB position of byte i in a 128-bit block (127 - 8*i).
    function automatic logic [6:0] byte_msb(input logic [3:0] i);
        return {~i, 3'b111};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            return RCON[rnd];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[byte_msb(4'(i)) -: 8] = sbox(s[byte_msb(4'(i)) -: 8]);
        end
        return res;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[byte_msb(byte_idx(2'(r), 2'(c))) -: 8] =
                    s[byte_msb(byte_idx(2'(r), 2'(c + r))) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[byte_msb(byte_idx(2'd0, 2'(c))) -: 8];
            a1 = s[byte_msb(byte_idx(2'd1, 2'(c))) -: 8];
            a2 = s[byte_msb(byte_idx(2'd2, 2'(c))) -: 8];
            a3 = s[byte_msb(byte_idx(2'd3, 2'(c))) -: 8];
            res[byte_msb(byte_idx(2'd0, 2'(c))) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[byte_msb(byte_idx(2'd1, 2'(c))) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[byte_msb(byte_idx(2'd2, 2'(c))) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[byte_msb(byte_idx(2'd3, 2'(c))) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return res;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] rk);
        return s ^ rk;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one step of the AES-128 on-the-fly key schedule (combinational).
//   rk_i      : current round key (w0 in bits 127:96)
//   rcon_i    : round constant for the key being produced
//   rk_next_o : next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_next_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0  = rk_i[127:96];
        w1  = rk_i[95:64];
        w2  = rk_i[63:32];
        w3  = rk_i[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w0 ^ sub ^ {rcon_i, 24'h0};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        rk_next_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer, one round per clock.
//   clk, rst_n            : clock and asynchronous active-low reset
//   in_valid / in_ready   : plaintext + key handshake (accepted only in IDLE)
//   plaintext, key        : 128-bit inputs, bit 127 = byte 0, column-major
//   out_valid / out_ready : ciphertext handshake, result held until taken
//   ciphertext            : result block
//   busy                  : high while a block is in flight or waiting in DONE
//   round                 : current round index, 0 when idle
// NR sets the round count (1..NR_MAX); values below 10 are reduced-round debug builds.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
);

    if (NR < 1 || NR > NR_MAX) begin : g_nr_check
        $error("aes_round_ctrl: NR out of range");
    end

    localparam logic [3:0] LastFull   = 4'(NR - 1);
    localparam aes_state_e FirstState = (NR > 1) ? StRound : StFinal;

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;

    // Shared round datapath.
    logic [127:0] rk_next;
    logic [127:0] sb_out, sr_out, mc_out, mc_sel, round_out;

    aes_key_step u_key_step (
        .rk_i      (rk_q),
        .rcon_i    (rcon_of(rnd_q)),
        .rk_next_o (rk_next)
    );

    always_comb begin
        sb_out    = sub_bytes(st_q);
        sr_out    = shift_rows(sb_out);
        mc_out    = mix_columns(sr_out);
        // Final round bypasses MixColumns.
        mc_sel    = (fsm_q == StFinal) ? sr_out : mc_out;
        round_out = add_round_key(mc_sel, rk_next);
    end

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    st_d       = plaintext ^ key;
                    rk_d       = key;
                    rnd_d      = 4'd1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    fsm_d      = FirstState;
                end
            end
            StRound: begin
                st_d  = round_out;
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LastFull) begin
                    fsm_d = StFinal;
                end
            end
            StFinal: begin
                st_d        = round_out;
                rk_d        = rk_next;
                ct_d        = round_out;
                out_valid_d = 1'b1;
                fsm_d       = StDone;
            end
            StDone: begin
                // New input is only taken from IDLE, i.e. the cycle after the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rnd_d       = 4'd0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;
    assign busy       = busy_q;
    assign round      = rnd_q;

    a_in_valid_known : assert property (@(posedge clk) disable iff (!rst_n)
        (fsm_q == StIdle) |-> !$isunknown(in_valid));

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] Z1_CT  = 128'h01000000010000000100000001000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;

    logic         ir0, ov0, busy0, ir1, ov1, busy1;
    logic [127:0] ct0, ct1;
    logic [3:0]   rnd0, rnd1;

    logic         ir_a [2];
    logic         ov_a [2];
    logic         busy_a [2];
    logic [127:0] ct_a [2];
    logic [3:0]   rnd_a [2];

    assign ir_a[0] = ir0;     assign ir_a[1] = ir1;
    assign ov_a[0] = ov0;     assign ov_a[1] = ov1;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1;
    assign ct_a[0] = ct0;     assign ct_a[1] = ct1;
    assign rnd_a[0] = rnd0;   assign rnd_a[1] = rnd1;

    aes_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .plaintext(plaintext), .key(key), .out_valid(ov0), .out_ready(out_ready),
        .ciphertext(ct0), .busy(busy0), .round(rnd0)
    );

    aes_round_ctrl #(.NR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .plaintext(plaintext), .key(key), .out_valid(ov1), .out_ready(out_ready),
        .ciphertext(ct1), .busy(busy1), .round(rnd1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int nrs [2] = '{10, 1};

    // ---------------- reference AES, built from GF(2^8) arithmetic ----------------
    bit [7:0] tb_sbox [256];
    bit [7:0] tb_rcon [11];

    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [7:0] p = 8'h00;
        bit hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
        for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
        return b;
    endfunction

    task automatic build_tables();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
        tb_rcon[0] = 8'h00;
        tb_rcon[1] = 8'h01;
        for (int i = 2; i < 11; i++) tb_rcon[i] = gmul(tb_rcon[i-1], 8'h02);
    endtask

    function automatic bit [127:0] aes_ref(input bit [127:0] pt, input bit [127:0] k,
                                           input int nr);
        bit [31:0]  w [44];
        bit [31:0]  tmp;
        bit [7:0]   s [16];
        bit [7:0]   t [16];
        bit [7:0]   a [4];
        bit [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
        for (int i = 4; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]],
                       tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]} ^ {tb_rcon[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (120 - 8 * i));
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = tb_sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        t[4*c + row] = s[4*((c + row) % 4) + row];
                s = t;
                if (r < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int row = 0; row < 4; row++) a[row] = s[4*c + row];
                        for (int row = 0; row < 4; row++)
                            s[4*c + row] = gmul(a[row], 8'h02) ^ gmul(a[(row+1)%4], 8'h03)
                                           ^ a[(row+2)%4] ^ a[(row+3)%4];
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] ^= 8'(w[4*r + c] >> (24 - 8 * row));
        end
        res = '0;
        for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
        return res;
    endfunction

    // ---------------- cycle model: time since accept per DUT ----------------
    bit         m_busy [2];
    int         m_edges [2];
    bit [127:0] m_ct [2];
    bit [127:0] m_out [2];

    always @(posedge clk or negedge rst_n) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_busy[j]  <= 1'b0;
                m_edges[j] <= 0;
                m_ct[j]    <= '0;
                m_out[j]   <= '0;
            end else if (!m_busy[j]) begin
                if (in_valid) begin
                    m_busy[j]  <= 1'b1;
                    m_edges[j] <= 1;
                    m_ct[j]    <= aes_ref(plaintext, key, nrs[j]);
                end
            end else if (m_edges[j] <= nrs[j]) begin
                m_edges[j] <= m_edges[j] + 1;
                if (m_edges[j] == nrs[j]) m_out[j] <= m_ct[j];
            end else if (out_ready) begin
                m_busy[j] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit       e_ov;
        int       e_rnd;
        if (rst_n && chk_en) begin
            for (int j = 0; j < 2; j++) begin
                e_ov  = m_busy[j] && (m_edges[j] == nrs[j] + 1);
                e_rnd = !m_busy[j] ? 0 : (m_edges[j] < nrs[j] ? m_edges[j] : nrs[j]);
                n_checks++;
                if (ir_a[j] == !m_busy[j] && ov_a[j] == e_ov && busy_a[j] == m_busy[j] &&
                    int'(rnd_a[j]) == e_rnd && ct_a[j] == m_out[j]) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_cmp nr=%0d t=%0t: got ir=%b ov=%b busy=%b rnd=%0d ct=%h, want ir=%b ov=%b busy=%b rnd=%0d ct=%h",
                             nrs[j], $time, ir_a[j], ov_a[j], busy_a[j], rnd_a[j], ct_a[j],
                             !m_busy[j], e_ov, m_busy[j], e_rnd, m_out[j]);
                end
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int j = 0; j < 2; j++) begin
            check(name, {ir_a[j], ov_a[j], busy_a[j], rnd_a[j]}, {1'b1, 1'b0, 1'b0, 4'd0});
            check(name, ct_a[j], '0);
        end
    endtask

    // Called at posedge+2; accept happens on the next edge.
    task automatic send(input logic [127:0] p, input logic [127:0] k);
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        @(posedge clk); #2;
        in_valid  = 1'b0;
    endtask

    // lat counts edges since and including the accept edge.
    task automatic wait_out(input int j, input int start, output int lat);
        lat = start;
        while (!ov_a[j] && lat < 64) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ir_a[0] && ir_a[1]) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("wait_idle", {31'd0, ir_a[0] && ir_a[1]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        build_tables();

        // Pin the reference model to hand-known values.
        check("model_sbox_00", {120'd0, tb_sbox[8'h00]}, 128'h63);
        check("model_sbox_53", {120'd0, tb_sbox[8'h53]}, 128'hed);
        check("model_c1", aes_ref(C1_PT, C1_KEY, 10), C1_CT);
        check("model_appb", aes_ref(B_PT, B_KEY, 10), B_CT);
        check("model_nr1_zero", aes_ref('0, '0, 1), Z1_CT);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // FIPS-197 C.1 with latency.
        wait_idle();
        send(C1_PT, C1_KEY);
        wait_out(0, 1, lat);
        check("c1_latency", 128'(lat), 128'd11);
        check("c1_ct", ct0, C1_CT);

        // Backpressure, then App. B back-to-back.
        wait_idle();
        out_ready = 1'b0;
        send(C1_PT, C1_KEY);
        wait_out(0, 1, lat);
        check("bp_latency", 128'(lat), 128'd11);
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #2;
            check("bp_hold_ct", ct0, C1_CT);
            check("bp_hold_flags", {ov0, ir0, rnd0}, {1'b1, 1'b0, 4'd10});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_release_idle", {ir0, ov0, busy0, rnd0}, {1'b1, 1'b0, 1'b0, 4'd0});
        send(B_PT, B_KEY);
        @(posedge clk); #2;
        check("appb_rk1", dut.rk_q, B_RK1);
        wait_out(0, 2, lat);
        check("appb_latency", 128'(lat), 128'd11);
        check("appb_ct", ct0, B_CT);

        // Reset in the middle of round 5.
        wait_idle();
        send(C1_PT, C1_KEY);
        lat = 0;
        while (rnd0 != 4'd5 && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        check("reached_round5", {124'd0, rnd0}, 128'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        send(C1_PT, C1_KEY);
        wait_out(0, 1, lat);
        check("post_reset_ct", ct0, C1_CT);

        // Inputs change after accept.
        wait_idle();
        send(C1_PT, C1_KEY);
        lat = 1;
        while (!ov0 && lat < 64) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #2;
            lat++;
        end
        check("input_change_latency", 128'(lat), 128'd11);
        check("input_change_ct", ct0, C1_CT);

        // Reduced-round build, all-zero vector.
        wait_idle();
        send('0, '0);
        wait_out(1, 1, lat);
        check("nr1_latency", 128'(lat), 128'd2);
        check("nr1_ct", ct1, Z1_CT);

        // Randomised traffic with random backpressure.
        wait_idle();
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
